dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Sequential arbiter that shares the single data-memory port between the processor memory stage and the DMA engine. It sits between the processor's data-memory outputs, the DMA engine and the data memory. It grants one requester per cycle, locks the port for DMA bursts up to a bounded length, routes 1-cycle-latency read data back to the requester that issued the read, and stalls the processor whenever it is denied.

## Interface
Parameters:
- N, 32, data and address width
- MAX_BURST, 8, maximum consecutive DMA beats while the CPU is waiting (≥1)
- ADDR_LIMIT, 32'h3D08F, highest legal data-memory address

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-low
- cpu_req  in  1  processor memory-stage access valid
- cpu_we  in  1  processor write enable
- cpu_addr  in  N  processor address
- cpu_wdata  in  N  processor write data
- cpu_stall  out  1  processor request not granted this cycle
- cpu_rdata  out  N  read data returned to processor
- cpu_rvalid  out  1  cpu_rdata valid
- dma_req  in  1  DMA beat valid
- dma_we  in  1  DMA write enable
- dma_addr  in  N  DMA address
- dma_wdata  in  N  DMA write data
- dma_last  in  1  current DMA beat ends the burst
- dma_gnt  out  1  DMA beat accepted this cycle
- dma_rdata  out  N  read data returned to DMA
- dma_rvalid  out  1  dma_rdata valid
- mem_we  out  1  data-memory write enable
- mem_addr  out  N  data-memory address
- mem_wdata  out  N  data-memory write data
- mem_rdata  in  N  data-memory read data, valid one cycle after its address
- addr_err  out  1  registered pulse: the granted access was out of range

## Operation
- The FSM has three states: IDLE, CPU_OWN and DMA_OWN. The grant is a combinational function of the state and the requests. The state is registered.
- IDLE or CPU_OWN:
  - cpu_req wins, and the CPU has fixed priority. The next state is CPU_OWN.
  - Otherwise dma_req is granted, the next state is DMA_OWN and beat_cnt is set to 1.
  - With no request, the next state is IDLE.
- DMA_OWN:
  - dma_req is granted if dma_req=1 and not (cpu_req=1 and beat_cnt ≥ MAX_BURST).
  - On a granted beat, beat_cnt is incremented and saturates at MAX_BURST.
  - A granted beat with dma_last=1 releases the port. The next state is CPU_OWN if cpu_req=1, otherwise IDLE.
  - dma_req=0 releases the port the same way.
  - A forced yield (cpu_req=1 and beat_cnt=MAX_BURST) grants the CPU that cycle. The next state is CPU_OWN and beat_cnt is cleared. The DMA re-arbitrates later as a fresh burst.
- Exactly one requester is granted per cycle. cpu_stall = cpu_req & ~cpu_grant. dma_gnt = dma_grant.
- Memory outputs mux the granted requester's we/addr/wdata. With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Range check: if the granted addr > ADDR_LIMIT, then mem_addr=0 and mem_we=0, and addr_err pulses high the next cycle. The grant still completes, so no deadlock.
- Read return:
  - A registered tag rd_owner ∈ {NONE, CPU, DMA} records who issued a granted read (we=0).
  - The next cycle, mem_rdata is steered to that requester with its rvalid=1. The other requester sees rdata=0 and rvalid=0.
  - Writes set the tag to NONE.

## Timing
- Grant is the same cycle as the request (combinational). Write data is committed at the grant edge. Read data arrives 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. The read tag pipeline is one register deep.
- Simultaneous requests from IDLE or CPU_OWN: the CPU is granted and the DMA waits.
- Simultaneous requests in DMA_OWN below MAX_BURST: the DMA is granted and the CPU stalls.
- Reset (rst=0, asynchronous):
  - state=IDLE, beat_cnt=0, rd_owner=NONE, addr_err=0.
  - The combinational outputs then follow IDLE rules: cpu_rvalid=dma_rvalid=0 and both rdata=0.
- Reset mid-burst abandons the burst. A read in flight is dropped, and no rvalid is produced after reset.
- cpu_stall must be glitch-free with respect to registered state. It depends only on the state, beat_cnt and the request inputs.

## Structure
- Shared package `arb_pkg`: enum arb_state_t {IDLE, CPU_OWN, DMA_OWN}, enum rd_owner_t {NONE, CPU, DMA}, and the default ADDR_LIMIT constant (also used by the processor's address clamp).
- A single module. The burst counter may be split out as sub-module `burst_counter` (saturating up-counter with clear).

## Test plan
- Reset pulse (rst low for 3 cycles) with both requests high: all outputs are 0 and state=IDLE. After release, the CPU is granted first.
- CPU write addr=0x100, data=0xDEADBEEF, then a CPU read of 0x100: mem_we=1 in cycle 1. cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 3.
- DMA burst of 4 reads at 0x200..0x20C (dma_last on the 4th), no CPU activity: dma_gnt=1 for 4 cycles. dma_rvalid follows each beat by 1 cycle, and the state is IDLE afterwards.
- DMA 12-beat burst with cpu_req raised at beat 2 and MAX_BURST=8: the CPU stalls until beat_cnt reaches 8. The CPU is then granted on the 9th cycle and cpu_stall falls. The DMA resumes as a new burst.
- CPU write to 0x3D090: mem_we=0 and mem_addr=0. addr_err pulses the next cycle and no stall persists.
- Alternating CPU read and DMA read in consecutive cycles: each rdata reaches only its issuer. The other rvalid stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   arb_state_t    : arbiter FSM states (port owner)
//   rd_owner_t     : which requester a returning read belongs to
//   ARB_ADDR_LIMIT : highest legal data-memory address; the processor's
//                    address clamp uses the same constant
//   cnt_width      : bits needed to hold a beat count from 0 to max
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        DMA_OWN = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } rd_owner_t;

    localparam logic [31:0] ARB_ADDR_LIMIT = 32'h0003_D08F;

    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Saturating DMA beat counter.
//   clk, rst      : clock, asynchronous active-low reset
//   clr           : force the count to zero (highest priority)
//   load_one      : start a fresh burst (count = 1)
//   inc           : count one more beat, holding at MAX
//   count         : current beat count
module burst_counter #(
    parameter int MAX = 8,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load_one,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: clear, fresh burst, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (load_one) begin
            count_d = W'(1);
        end else if (inc && (count_q < MAX_CNT)) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the processor memory stage
// and the DMA engine. One requester is granted per cycle (combinationally);
// the CPU has fixed priority except while the DMA owns the port for a burst,
// which it keeps until dma_last, an idle beat, or MAX_BURST beats with the
// CPU waiting. Read data (1-cycle latency) is steered to its issuer.
//   clk, rst                       : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata          : processor access request
//   cpu_stall                      : processor request denied this cycle
//   cpu_rdata/cpu_rvalid           : read return to processor
//   dma_req/we/addr/wdata/last     : DMA beat request
//   dma_gnt                        : DMA beat accepted this cycle
//   dma_rdata/dma_rvalid           : read return to DMA
//   mem_we/addr/wdata, mem_rdata   : data-memory port
//   addr_err                       : registered pulse, granted access out of range
module dmem_port_arbiter
    import arb_pkg::*;
#(
    parameter int          N          = 32,
    parameter int          MAX_BURST  = 8,
    parameter logic [31:0] ADDR_LIMIT = ARB_ADDR_LIMIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [N-1:0] cpu_addr,
    input  logic [N-1:0] cpu_wdata,
    output logic         cpu_stall,
    output logic [N-1:0] cpu_rdata,
    output logic         cpu_rvalid,
    input  logic         dma_req,
    input  logic         dma_we,
    input  logic [N-1:0] dma_addr,
    input  logic [N-1:0] dma_wdata,
    input  logic         dma_last,
    output logic         dma_gnt,
    output logic [N-1:0] dma_rdata,
    output logic         dma_rvalid,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         addr_err
);

    localparam int           CW      = cnt_width(MAX_BURST);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic [N-1:0]  LIMIT   = N'(ADDR_LIMIT);

    arb_state_t state_d, state_q;
    rd_owner_t  rd_owner_d, rd_owner_q;
    logic       addr_err_d, addr_err_q;

    logic          cpu_grant_s;
    logic          dma_grant_s;
    logic          cnt_clr_s;
    logic          cnt_load_s;
    logic          cnt_inc_s;
    logic [CW-1:0] beat_cnt_s;

    logic          sel_we_s;
    logic [N-1:0]  sel_addr_s;
    logic [N-1:0]  sel_wdata_s;
    logic          range_err_s;

    burst_counter #(
        .MAX (MAX_BURST),
        .W   (CW)
    ) u_burst_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .load_one (cnt_load_s),
        .inc      (cnt_inc_s),
        .count    (beat_cnt_s)
    );

    // Grant and next-state decision; depends only on registered state,
    // beat count and request inputs so cpu_stall never sees data paths.
    always_comb begin
        cpu_grant_s = 1'b0;
        dma_grant_s = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_inc_s   = 1'b0;
        state_d     = state_q;
        case (state_q)
            IDLE, CPU_OWN: begin
                if (cpu_req) begin
                    cpu_grant_s = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_d     = CPU_OWN;
                end else if (dma_req) begin
                    dma_grant_s = 1'b1;
                    cnt_load_s  = 1'b1;
                    state_d     = DMA_OWN;
                end else begin
                    state_d     = IDLE;
                end
            end
            DMA_OWN: begin
                if (cpu_req && (beat_cnt_s >= MAX_CNT)) begin
                    // Forced yield: the DMA comes back later as a fresh burst.
                    cpu_grant_s = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_d     = CPU_OWN;
                end else if (dma_req) begin
                    dma_grant_s = 1'b1;
                    if (dma_last) begin
                        cnt_clr_s = 1'b1;
                        state_d   = cpu_req ? CPU_OWN : IDLE;
                    end else begin
                        cnt_inc_s = 1'b1;
                        state_d   = DMA_OWN;
                    end
                end else begin
                    // DMA went quiet: release; a waiting CPU takes the idle slot.
                    cnt_clr_s = 1'b1;
                    if (cpu_req) begin
                        cpu_grant_s = 1'b1;
                        state_d     = CPU_OWN;
                    end else begin
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // Memory port mux, range check and read-tag / error next values.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {N{1'b0}};
        sel_wdata_s = {N{1'b0}};
        rd_owner_d  = NONE;
        if (cpu_grant_s) begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
            rd_owner_d  = cpu_we ? NONE : CPU;
        end else if (dma_grant_s) begin
            sel_we_s    = dma_we;
            sel_addr_s  = dma_addr;
            sel_wdata_s = dma_wdata;
            rd_owner_d  = dma_we ? NONE : DMA;
        end else begin
            rd_owner_d  = NONE;
        end
        range_err_s = (cpu_grant_s || dma_grant_s) && (sel_addr_s > LIMIT);
        addr_err_d  = range_err_s;
    end

    // FSM state, read-owner tag and address-error pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_owner_q <= NONE;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_grant_s;
    assign dma_gnt    = dma_grant_s;

    // An out-of-range access still completes its grant but cannot touch memory.
    assign mem_we     = sel_we_s & ~range_err_s;
    assign mem_addr   = range_err_s ? {N{1'b0}} : sel_addr_s;
    assign mem_wdata  = sel_wdata_s;

    assign cpu_rvalid = (rd_owner_q == CPU);
    assign dma_rvalid = (rd_owner_q == DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : {N{1'b0}};
    assign dma_rdata  = dma_rvalid ? mem_rdata : {N{1'b0}};
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a 1-cycle-latency
// memory model. Unwritten words read back as 32'hA000_0000 | address.
module tb_dmem_port_arbiter;
    import arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_we, addr_err;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_cmp;
    int n_err;

    bit   [31:0] mem_arr [0:1023];
    bit          wr_flag [0:1023];

    dmem_port_arbiter #(
        .N          (32),
        .MAX_BURST  (8),
        .ADDR_LIMIT (32'h0003_D08F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_last   (dma_last),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .addr_err   (addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: write at the edge, read data registered one cycle later.
    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_addr[11:2]] <= mem_wdata;
            wr_flag[mem_addr[11:2]] <= 1'b1;
        end
        mem_rdata <= wr_flag[mem_addr[11:2]] ? mem_arr[mem_addr[11:2]]
                                             : (32'hA000_0000 | mem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        dma_last = 1'b0;
    endtask

    task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    endtask

    task automatic dma_drive(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             input logic last);
        dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data; dma_last = last;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();

        // ---- Reset with both requests high ----
        rst = 1'b0;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        repeat (3) tick();
        check_eq("rst_dma_gnt",   {31'h0, dma_gnt},    32'h0);
        check_eq("rst_cpu_stall", {31'h0, cpu_stall},  32'h0);
        check_eq("rst_cpu_rvld",  {31'h0, cpu_rvalid}, 32'h0);
        check_eq("rst_dma_rvld",  {31'h0, dma_rvalid}, 32'h0);
        check_eq("rst_rdata",     cpu_rdata | dma_rdata, 32'h0);
        check_eq("rst_mem",       {31'h0, mem_we} | mem_addr | mem_wdata, 32'h0);
        check_eq("rst_addr_err",  {31'h0, addr_err},   32'h0);
        check_eq("rst_state",     32'(dut.state_q),    32'(IDLE));
        rst = 1'b1;
        #1;
        check_eq("post_rst_cpu_first", {30'h0, dma_gnt, cpu_stall}, 32'h0);
        tick();
        check_eq("post_rst_state", 32'(dut.state_q), 32'(CPU_OWN));
        idle_inputs();
        tick();

        // ---- CPU write then read ----
        cpu_drive(1'b1, 32'h100, 32'hDEAD_BEEF);
        #1;
        check_eq("wr_mem_we",    {31'h0, mem_we}, 32'h1);
        check_eq("wr_mem_addr",  mem_addr,        32'h100);
        check_eq("wr_mem_wdata", mem_wdata,       32'hDEAD_BEEF);
        tick();
        cpu_drive(1'b0, 32'h100, 32'h0);
        #1;
        check_eq("rd_mem_we",    {31'h0, mem_we}, 32'h0);
        check_eq("rd_cpu_stall", {31'h0, cpu_stall}, 32'h0);
        tick();
        idle_inputs();
        #1;
        check_eq("rd_cpu_rvalid", {31'h0, cpu_rvalid}, 32'h1);
        check_eq("rd_cpu_rdata",  cpu_rdata, 32'hDEAD_BEEF);
        check_eq("rd_dma_rvalid", {31'h0, dma_rvalid}, 32'h0);
        tick();

        // ---- DMA 4-beat read burst ----
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                dma_drive(1'b0, 32'h200 + 32'(4 * i), 32'h0, (i == 3));
            end else begin
                idle_inputs();
            end
            #1;
            if (i < 4) begin
                check_eq($sformatf("burst4_gnt%0d", i), {31'h0, dma_gnt}, 32'h1);
            end
            if (i > 0) begin
                check_eq($sformatf("burst4_rvld%0d", i), {31'h0, dma_rvalid}, 32'h1);
                check_eq($sformatf("burst4_rdata%0d", i), dma_rdata,
                         32'hA000_0200 + 32'(4 * (i - 1)));
                check_eq($sformatf("burst4_cpurv%0d", i), {31'h0, cpu_rvalid}, 32'h0);
            end
            tick();
        end
        check_eq("burst4_state", 32'(dut.state_q), 32'(IDLE));

        // ---- 12-beat DMA write burst with CPU waiting from beat 2 ----
        for (int c = 0; c < 9; c++) begin
            dma_drive(1'b1, 32'h300 + 32'(4 * c), 32'h0000_0100 + 32'(c), 1'b0);
            if (c >= 1) begin
                cpu_drive(1'b1, 32'h400, 32'h0000_0055);
            end
            #1;
            if (c < 8) begin
                check_eq($sformatf("long_gnt%0d", c), {31'h0, dma_gnt}, 32'h1);
                check_eq($sformatf("long_stall%0d", c), {31'h0, cpu_stall}, (c >= 1) ? 32'h1 : 32'h0);
            end else begin
                check_eq("yield_dma_gnt",  {31'h0, dma_gnt},   32'h0);
                check_eq("yield_stall",    {31'h0, cpu_stall}, 32'h0);
                check_eq("yield_mem_addr", mem_addr,           32'h400);
            end
            tick();
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        for (int b = 8; b < 12; b++) begin
            dma_drive(1'b1, 32'h300 + 32'(4 * b), 32'h0000_0100 + 32'(b), (b == 11));
            #1;
            check_eq($sformatf("resume_gnt%0d", b), {31'h0, dma_gnt}, 32'h1);
            tick();
            if (b == 8) begin
                check_eq("resume_cnt", 32'(dut.beat_cnt_s), 32'h1);
            end
        end
        idle_inputs();
        check_eq("long_end_state", 32'(dut.state_q), 32'(IDLE));
        tick();

        // ---- Address range boundary ----
        cpu_drive(1'b1, 32'h0003_D08F, 32'h1234_5678);
        #1;
        check_eq("lim_ok_we",   {31'h0, mem_we}, 32'h1);
        check_eq("lim_ok_addr", mem_addr,        32'h0003_D08F);
        tick();
        cpu_drive(1'b1, 32'h0003_D090, 32'h1234_5678);
        #1;
        check_eq("oor_we",    {31'h0, mem_we},    32'h0);
        check_eq("oor_addr",  mem_addr,           32'h0);
        check_eq("oor_stall", {31'h0, cpu_stall}, 32'h0);
        check_eq("oor_err_early", {31'h0, addr_err}, 32'h0);
        tick();
        idle_inputs();
        #1;
        check_eq("oor_err_pulse", {31'h0, addr_err}, 32'h1);
        tick();
        check_eq("oor_err_clear", {31'h0, addr_err}, 32'h0);

        // ---- Alternating CPU / DMA reads ----
        cpu_drive(1'b0, 32'h100, 32'h0);
        #1;
        check_eq("alt_cpu_gnt", {31'h0, cpu_stall}, 32'h0);
        tick();
        idle_inputs();
        dma_drive(1'b0, 32'h200, 32'h0, 1'b1);
        #1;
        check_eq("alt_dma_gnt", {31'h0, dma_gnt},    32'h1);
        check_eq("alt1_cpu_rv", {31'h0, cpu_rvalid}, 32'h1);
        check_eq("alt1_cpu_rd", cpu_rdata,           32'hDEAD_BEEF);
        check_eq("alt1_dma_rv", {31'h0, dma_rvalid}, 32'h0);
        check_eq("alt1_dma_rd", dma_rdata,           32'h0);
        tick();
        idle_inputs();
        cpu_drive(1'b0, 32'h204, 32'h0);
        #1;
        check_eq("alt_cpu_gnt2", {31'h0, cpu_stall}, 32'h0);
        check_eq("alt2_dma_rv",  {31'h0, dma_rvalid}, 32'h1);
        check_eq("alt2_dma_rd",  dma_rdata,           32'hA000_0200);
        check_eq("alt2_cpu_rv",  {31'h0, cpu_rvalid}, 32'h0);
        check_eq("alt2_cpu_rd",  cpu_rdata,           32'h0);
        tick();
        idle_inputs();
        #1;
        check_eq("alt3_cpu_rv", {31'h0, cpu_rvalid}, 32'h1);
        check_eq("alt3_cpu_rd", cpu_rdata,           32'hA000_0204);
        check_eq("alt3_dma_rv", {31'h0, dma_rvalid}, 32'h0);
        tick();

        // ---- Reset with a read in flight drops the return ----
        cpu_drive(1'b0, 32'h100, 32'h0);
        #1;
        rst = 1'b0;
        idle_inputs();
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_drop_rvalid", {31'h0, cpu_rvalid}, 32'h0);
        check_eq("rst_drop_rdata",  cpu_rdata,           32'h0);
        tick();
        check_eq("rst_drop_rvalid2", {31'h0, cpu_rvalid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
